// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if: request/issue bus between the NTT sequencer and its neighbours.
//   start, mode                 : transform request from the polynomial-op FSM
//   rd_en, rd_addr_a/b, tw_idx  : butterfly issue (RAM read + twiddle ROM)
//   bf_sel                      : butterfly CT(1)/GS(0) select
//   wr_en, wr_addr_a/b          : write-back of butterfly results
//   busy, done                  : transform status
// master = sequencer side, slave = requester/datapath side.
interface ntt_ctrl_if #(
  parameter int AW = 8,
  parameter int ZW = 7
);
  logic          start;
  logic          mode;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [ZW-1:0] tw_idx;
  logic          bf_sel;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;
  logic          busy;
  logic          done;

  modport master (
    input  start, mode,
    output rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_sel,
    output wr_en, wr_addr_a, wr_addr_b, busy, done
  );

  modport slave (
    output start, mode,
    input  rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_sel,
    input  wr_en, wr_addr_a, wr_addr_b, busy, done
  );
endinterface

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: address/twiddle sequencer for one Kyber NTT (CT) or inverse NTT (GS)
// over a 2^AW-coefficient polynomial, one butterfly per cycle.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : ntt_ctrl_if.master (start/mode in; read issue, twiddle, bf_sel,
//              delayed write-back, busy/done out)
//   cyc_cnt  : 16-bit busy-cycle counter, present only when the macro
//              NTT_CTRL_CYCLE_CNT_EN is defined
// Each stage issues N/2 butterflies, then drains for LAT = 1 + BFLAT cycles so
// every write of the stage has landed before the next stage reads.
module ntt_ctrl #(
  parameter int AW    = 8,
  parameter int ZW    = 7,
  parameter int BFLAT = 3
) (
  input  logic      clk,
  input  logic      rst,
  ntt_ctrl_if.master bus
`ifdef NTT_CTRL_CYCLE_CNT_EN
  ,
  output logic [15:0] cyc_cnt
`endif
);
  localparam int LAT  = BFLAT + 1;
  localparam int NSTG = AW - 1;
  localparam int SW   = $clog2(NSTG);
  localparam int DW   = $clog2(LAT) + 1;
  localparam logic [AW-1:0] LEN_FWD = AW'(1 << (AW - 1));
  localparam logic [AW-1:0] LEN_INV = AW'(2);
  localparam logic [ZW-1:0] K_FWD   = ZW'(1);
  localparam logic [ZW-1:0] K_INV   = ZW'((1 << (AW - 1)) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic          fwd;
  logic [AW-1:0] len, s, j;
  logic [ZW-1:0] k;
  logic [AW-2:0] cnt;     // butterflies issued in the current stage
  logic [SW-1:0] stage;
  logic [DW-1:0] dcnt;

  logic          grp_end;
  logic [AW-1:0] s_nxt, j_inc, len_nxt;
  logic [ZW-1:0] k_nxt;

  always_comb begin
    grp_end = (j == s + len - AW'(1));
    s_nxt   = s + (len << 1);
    j_inc   = j + AW'(1);
    len_nxt = fwd ? (len >> 1) : (len << 1);
    k_nxt   = fwd ? (k + ZW'(1)) : (k - ZW'(1));
  end

  // Registers j/s/k/len describe the butterfly currently on the read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fwd           <= 1'b0;
      len           <= '0;
      s             <= '0;
      j             <= '0;
      k             <= '0;
      cnt           <= '0;
      stage         <= '0;
      dcnt          <= '0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr_a <= '0;
      bus.rd_addr_b <= '0;
      bus.tw_idx    <= '0;
      bus.bf_sel    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            fwd           <= bus.mode;
            len           <= bus.mode ? LEN_FWD : LEN_INV;
            s             <= '0;
            j             <= '0;
            k             <= bus.mode ? K_FWD : K_INV;
            cnt           <= '0;
            stage         <= '0;
            bus.rd_en     <= 1'b1;
            bus.rd_addr_a <= '0;
            bus.rd_addr_b <= bus.mode ? LEN_FWD : LEN_INV;
            bus.tw_idx    <= bus.mode ? K_FWD : K_INV;
            bus.bf_sel    <= bus.mode;
            bus.busy      <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          if (cnt == '1) begin
            bus.rd_en     <= 1'b0;
            bus.rd_addr_a <= '0;
            bus.rd_addr_b <= '0;
            bus.tw_idx    <= '0;
            dcnt          <= '0;
            state         <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
            if (grp_end) begin
              s             <= s_nxt;
              j             <= s_nxt;
              k             <= k_nxt;
              bus.rd_addr_a <= s_nxt;
              bus.rd_addr_b <= s_nxt + len;
              bus.tw_idx    <= k_nxt;
            end else begin
              j             <= j_inc;
              bus.rd_addr_a <= j_inc;
              bus.rd_addr_b <= j_inc + len;
            end
          end
        end
        DRAIN: begin
          if (dcnt == DW'(LAT - 1)) begin
            if (stage == SW'(NSTG - 1)) begin
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              bus.bf_sel <= 1'b0;
              state      <= DONE;
            end else begin
              // A new stage is also a new group, so k steps here too.
              stage         <= stage + 1'b1;
              len           <= len_nxt;
              s             <= '0;
              j             <= '0;
              k             <= k_nxt;
              cnt           <= '0;
              bus.rd_en     <= 1'b1;
              bus.rd_addr_a <= '0;
              bus.rd_addr_b <= len_nxt;
              bus.tw_idx    <= k_nxt;
              state         <= RUN;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back pipe: index i holds the issue from i cycles ago.
  logic [LAT:1]         vld_pipe;
  logic [LAT:1][AW-1:0] a_pipe, b_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      vld_pipe[1] <= bus.rd_en;
      a_pipe[1]   <= bus.rd_addr_a;
      b_pipe[1]   <= bus.rd_addr_b;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        a_pipe[i]   <= a_pipe[i-1];
        b_pipe[i]   <= b_pipe[i-1];
      end
    end
  end

  assign bus.wr_en     = vld_pipe[LAT];
  assign bus.wr_addr_a = a_pipe[LAT];
  assign bus.wr_addr_b = b_pipe[LAT];

`ifdef NTT_CTRL_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                          cyc_cnt <= '0;
    else if (state == IDLE && bus.start) cyc_cnt <= '0;
    else if (bus.busy)                cyc_cnt <= cyc_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: self-checking bench for ntt_ctrl (AW=8, ZW=7, BFLAT=3).
// A loop-nest reference model builds the expected per-cycle issue and
// write-back schedule of a whole transform; each run is compared against it
// cycle by cycle, then a vector table spot-checks captured cycles.
module tb_ntt_ctrl;
  localparam int LAT    = 4;
  localparam int PER    = 128 + LAT;
  localparam int LASTWR = 7 * PER;
  localparam int DONEC  = LASTWR + 1;
  localparam int MAXC   = DONEC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_ctrl_if #(.AW(8), .ZW(7)) bus ();

`ifdef NTT_CTRL_CYCLE_CNT_EN
  logic [15:0] cyc_cnt;
`endif

  ntt_ctrl #(.AW(8), .ZW(7), .BFLAT(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef NTT_CTRL_CYCLE_CNT_EN
    ,
    .cyc_cnt(cyc_cnt)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit prev_full = 1'b0;

  bit e_en [MAXC+1];
  int e_a  [MAXC+1];
  int e_b  [MAXC+1];
  int e_tw [MAXC+1];
  bit e_wr [MAXC+1];
  int e_wa [MAXC+1];
  int e_wb [MAXC+1];

  bit cap_en  [2][MAXC+1];
  int cap_a   [2][MAXC+1];
  int cap_b   [2][MAXC+1];
  int cap_tw  [2][MAXC+1];
  bit cap_sel [2][MAXC+1];

  typedef struct {
    bit m; int cyc; bit en; int a; int b; int tw; bit sel;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input int c, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", nm, c, act, exp);
    end
  endtask

  // Reference schedule straight from the loop nest of the transform.
  task automatic build(input bit m);
    int c, k, len;
    for (int i = 0; i <= MAXC; i++) begin
      e_en[i] = 0; e_a[i] = 0; e_b[i] = 0; e_tw[i] = 0;
      e_wr[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
    end
    k = m ? 1 : 127;
    for (int st = 0; st < 7; st++) begin
      len = m ? (128 >> st) : (2 << st);
      c = 1 + st * PER;
      for (int s = 0; s < 256; s += 2 * len) begin
        for (int j = s; j < s + len; j++) begin
          e_en[c] = 1; e_a[c] = j; e_b[c] = j + len; e_tw[c] = k;
          e_wr[c+LAT] = 1; e_wa[c+LAT] = j; e_wb[c+LAT] = j + len;
          c++;
        end
        k = m ? k + 1 : k - 1;
      end
    end
  endtask

  task automatic chk_zero(input string nm, input int c);
    chk({nm, "_rd_en"}, c, bus.rd_en, 0);
    chk({nm, "_rd_a"}, c, bus.rd_addr_a, 0);
    chk({nm, "_rd_b"}, c, bus.rd_addr_b, 0);
    chk({nm, "_tw"}, c, bus.tw_idx, 0);
    chk({nm, "_bf_sel"}, c, bus.bf_sel, 0);
    chk({nm, "_wr_en"}, c, bus.wr_en, 0);
    chk({nm, "_wr_a"}, c, bus.wr_addr_a, 0);
    chk({nm, "_wr_b"}, c, bus.wr_addr_b, 0);
    chk({nm, "_busy"}, c, bus.busy, 0);
    chk({nm, "_done"}, c, bus.done, 0);
`ifdef NTT_CTRL_CYCLE_CNT_EN
    chk({nm, "_cyc_cnt"}, c, cyc_cnt, 0);
`endif
  endtask

  task automatic check_cycle(input int c, input bit m);
    bit bz;
    bz = (c >= 1 && c <= LASTWR);
    chk("rd_en", c, bus.rd_en, e_en[c]);
    if (e_en[c]) begin
      chk("rd_addr_a", c, bus.rd_addr_a, e_a[c]);
      chk("rd_addr_b", c, bus.rd_addr_b, e_b[c]);
      chk("tw_idx", c, bus.tw_idx, e_tw[c]);
    end
    chk("wr_en", c, bus.wr_en, e_wr[c]);
    if (e_wr[c]) begin
      chk("wr_addr_a", c, bus.wr_addr_a, e_wa[c]);
      chk("wr_addr_b", c, bus.wr_addr_b, e_wb[c]);
    end
    chk("busy", c, bus.busy, bz);
    chk("done", c, bus.done, c == DONEC);
    if (bz) chk("bf_sel", c, bus.bf_sel, m);
  endtask

  // One transform from the first idle cycle; junk_at pulses start mid-run,
  // rst_at (nonzero) asserts reset in that cycle and ends the run early.
  task automatic run(input bit m, input int junk_at, input int rst_at);
    int nwr;
    nwr = 0;
    build(m);
    @(negedge clk);
    chk("idle_busy", 0, bus.busy, 0);
    chk("idle_done", 0, bus.done, 0);
    chk("idle_rd_en", 0, bus.rd_en, 0);
`ifdef NTT_CTRL_CYCLE_CNT_EN
    if (prev_full) chk("cyc_cnt_hold", 0, cyc_cnt, LASTWR);
`endif
    bus.start = 1'b1;
    bus.mode  = m;
    for (int c = 1; c <= DONEC; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.mode  = 1'($urandom);
      if (rst_at != 0 && c == rst_at + 1) begin
        rst = 1'b0;
        chk_zero("after_rst", c);
        for (int i = 1; i <= 20; i++) begin
          @(negedge clk);
          chk("wr_en_after_rst", c + i, bus.wr_en, 0);
          chk("busy_after_rst", c + i, bus.busy, 0);
        end
        prev_full = 1'b0;
        return;
      end
      check_cycle(c, m);
      cap_en[m][c]  = bus.rd_en;
      cap_a[m][c]   = int'(bus.rd_addr_a);
      cap_b[m][c]   = int'(bus.rd_addr_b);
      cap_tw[m][c]  = int'(bus.tw_idx);
      cap_sel[m][c] = bus.bf_sel;
      if (bus.wr_en) nwr++;
`ifdef NTT_CTRL_CYCLE_CNT_EN
      if (c == 1) chk("cyc_cnt_clear", c, cyc_cnt, 0);
      if (c == DONEC) chk("cyc_cnt_done", c, cyc_cnt, LASTWR);
`endif
      if (c == junk_at) bus.start = 1'b1;
      if (c == rst_at) rst = 1'b1;
    end
    chk("wr_count", DONEC, nwr, 896);
    prev_full = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset", 0);
    rst = 1'b0;

    tv.push_back('{1'b1,   1, 1'b1,   0, 128,   1, 1'b1});
    tv.push_back('{1'b1, 128, 1'b1, 127, 255,   1, 1'b1});
    tv.push_back('{1'b1, 129, 1'b0,   0,   0,   0, 1'b1});
    tv.push_back('{1'b1, 133, 1'b1,   0,  64,   2, 1'b1});
    tv.push_back('{1'b1, 197, 1'b1, 128, 192,   3, 1'b1});
    tv.push_back('{1'b1, 920, 1'b1, 253, 255, 127, 1'b1});
    tv.push_back('{1'b0,   1, 1'b1,   0,   2, 127, 1'b0});
    tv.push_back('{1'b0,   2, 1'b1,   1,   3, 127, 1'b0});
    tv.push_back('{1'b0,   3, 1'b1,   4,   6, 126, 1'b0});
    tv.push_back('{1'b0, 133, 1'b1,   0,   4,  63, 1'b0});
    tv.push_back('{1'b0, 920, 1'b1, 127, 255,   1, 1'b0});

    run(1'b1, 300, 0);   // forward, ignored start+mode pulse at cycle 300
    run(1'b0, 0, 0);     // inverse, started in the cycle right after done

    foreach (tv[i]) begin
      chk("tv_rd_en", tv[i].cyc, cap_en[tv[i].m][tv[i].cyc], tv[i].en);
      if (tv[i].en) begin
        chk("tv_a", tv[i].cyc, cap_a[tv[i].m][tv[i].cyc], tv[i].a);
        chk("tv_b", tv[i].cyc, cap_b[tv[i].m][tv[i].cyc], tv[i].b);
        chk("tv_tw", tv[i].cyc, cap_tw[tv[i].m][tv[i].cyc], tv[i].tw);
        chk("tv_sel", tv[i].cyc, cap_sel[tv[i].m][tv[i].cyc], tv[i].sel);
      end
    end

    run(1'b1, 0, 140);   // reset mid-run
    run(1'b1, 0, 0);     // fresh forward run after reset

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run(1'($urandom), int'($urandom_range(2, 900)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer for the polynomial butterfly unit. It runs one full Kyber NTT or inverse NTT over a 256-coefficient polynomial held in a dual-port RAM, issuing one butterfly per cycle. It generates the read addresses, twiddle index and CT/GS mode select for the butterfly. It also generates write-back addresses, delayed to match the memory and butterfly pipeline. It sits between the polynomial-op top FSM (start/done) and the RAM, twiddle ROM and butterfly datapath. Final n^-1 scaling of the inverse transform is out of scope.

## Interface
- `AW`, 8: coefficient address width (N = 2^AW = 256).
- `ZW`, 7: twiddle index width.
- `BFLAT`, 3: butterfly input-to-output latency in cycles.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `mode` in 1: sampled with `start`; 1 = forward NTT (CT), 0 = inverse NTT (GS).
- `rd_en` out 1: RAM read strobe, one butterfly issued.
- `rd_addr_a` / `rd_addr_b` out AW: top and bottom coefficient addresses.
- `tw_idx` out ZW: twiddle ROM address, aligned with `rd_en`.
- `bf_sel` out 1: butterfly mode; equals latched `mode` while busy.
- `wr_en` out 1: RAM write strobe for butterfly results.
- `wr_addr_a` / `wr_addr_b` out AW: write addresses for the c/d outputs.
- `busy` out 1: transform in progress.
- `done` out 1: single-cycle completion pulse.
- Reset value of all outputs: 0.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **IDLE**: on `start`, latch `mode`, initialise len/group/j/k, and go to RUN.
- **Forward transform**: len = 128, 64, …, 2 (7 stages). k starts at 1 and increments at each new group.
- **Inverse transform**: len = 2, 4, …, 128. k starts at 127 and decrements at each new group.
- **Loop order**: group start s = 0, 2len, 4len, … (outer); j = s … s+len-1 (inner).
- **Per butterfly**: `rd_addr_a` = j, `rd_addr_b` = j+len, `tw_idx` = k.
- Each stage issues exactly 128 butterflies. k ends at 127 after the last forward group and at 1 after the last inverse group.
- **RUN**: `rd_en` = 1 every cycle. After the 128th issue of a stage, go to DRAIN.
- **DRAIN**: lasts LAT = 1 + BFLAT cycles, covering 1 RAM read cycle plus the butterfly latency, so all writes of a stage land before the next stage reads. There is no inter-stage RAW bypass.
  - DRAIN exits to RUN with the next len, or to DONE after stage 7.
- **DONE**: `done` = 1 and `busy` = 0 for one cycle, then IDLE.
- **Write path**: a shift pipe of depth LAT carries {valid, addr_a, addr_b}. `wr_en` / `wr_addr_*` equal `rd_en` / `rd_addr_*` delayed by exactly LAT cycles.
- `start` while not IDLE is ignored; `mode` changes mid-run are ignored.
- `rst` mid-run: return to IDLE in the next cycle, clear the write pipe, and produce no further `wr_en`.
- All counters are unsigned and wrap-free by construction. len uses AW bits, j and s use AW bits, k uses ZW bits.

## Timing
- `start` sampled at cycle 0; first `rd_en` at cycle 1; `busy` high from cycle 1.
- Stage i issues at cycles 1+i·(128+LAT) through 128+i·(128+LAT).
- Last `wr_en` occurs at 7·(128+LAT). `done` follows at 7·(128+LAT)+1 (cycle 925 for BFLAT = 3), with `busy` low in that cycle.
- `busy` is high for exactly 7·(128+LAT) cycles.
- `wr_en` asserts exactly 896 times per transform.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- **`NTT_CTRL_CYCLE_CNT_EN` defined**: adds output `cyc_cnt` (16 bits).
  - Cleared on accepted `start`.
  - Increments every cycle `busy` = 1.
  - Holds its value after `done` until the next `start`; resets to 0.
- **Not defined**: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Forward start, BFLAT = 3**:
  - Cycle 1: a = 0, b = 128, tw = 1, `bf_sel` = 1.
  - Cycle 128: a = 127, b = 255, tw = 1.
  - Cycle 133: a = 0, b = 64, tw = 2.
  - Cycle 197: a = 128, b = 192, tw = 3.
- **Forward final stage**: last issue a = 253, b = 255, tw = 127; `done` at cycle 925; 896 `wr_en` in total; each write address equals its read address 4 cycles earlier.
- **Inverse start**: cycle 1 a = 0, b = 2, tw = 127, `bf_sel` = 0; last issue of the run a = 127, b = 255, tw = 1.
- **Start while busy**: pulse `start` with `mode` = 0 at cycle 300 of a forward run. Required: no effect on addresses or `bf_sel`, and `done` still at cycle 925.
- **Reset mid-run**: assert `rst` at cycle 140. Required: next cycle all outputs 0; no `wr_en` afterward; a fresh `start` then reproduces the forward-start scenario exactly.
- **With `NTT_CTRL_CYCLE_CNT_EN`**: `cyc_cnt` = 924 at `done`; it holds 924 in IDLE and clears to 0 on the next `start`.
